rtsnoc_rx_fifo: RTL and testbench

Receive-side flit buffer between the RTSNoC router's local output port and the RTSNoC wishbone slave. It pops flits from the router with its own nd/rd handshake and stores them in a first-word-fall-through FIFO. It presents them downstream on an nd/rd interface the slave consumes unchanged. This decouples router back-pressure from CPU read latency. The transmit path does not pass through this block.

---
 rtl/rtsnoc_rx_fifo.sv | 121 ++++++++++++
 tb/tb_rtsnoc_rx_fifo.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtsnoc_rx_fifo.sv
// Receive-side FWFT flit buffer between the RTSNoC router local port and the wishbone slave.
// Optional destination filter enabled by defining RTSNOC_RX_FIFO_FILTER_EN.
module rtsnoc_rx_fifo #(
    parameter int unsigned SOC_SIZE_X     = 1,
    parameter int unsigned SOC_SIZE_Y     = 1,
    parameter int unsigned NOC_DATA_WIDTH = 16,
    parameter int unsigned NOC_LOCAL_ADR  = 0,
    parameter int unsigned NOC_X          = 0,
    parameter int unsigned NOC_Y          = 0,
    parameter int unsigned DEPTH_LOG2     = 3,
    localparam int unsigned BUS = NOC_DATA_WIDTH + 2 * SOC_SIZE_X + 2 * SOC_SIZE_Y + 6
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [BUS-1:0]        rtr_dout_i,
    input  logic                  rtr_nd_i,
    output logic                  rtr_rd_o,
    output logic [BUS-1:0]        noc_dout_o,
    output logic                  noc_nd_o,
    input  logic                  noc_rd_i,
    output logic [DEPTH_LOG2:0]   fifo_level_o,
    output logic [7:0]            drop_cnt_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_POP   = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                rtr_rd_q;
    logic                noc_rd_q;
    logic [DEPTH_LOG2:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0] level;
    logic                full, empty;
    logic                do_pop, wr_en;
    logic [BUS-1:0]      mem [DEPTH];

    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty = (level == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (rtr_nd_i && !full) state_d = ST_POP;
            ST_POP:   state_d = ST_GUARD;
            ST_GUARD: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // rtr_rd_q mirrors state POP, so it also marks the cycle the flit is captured.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            rtr_rd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rtr_rd_q <= (state_d == ST_POP);
        end
    end

    assign rtr_rd_o = rtr_rd_q;

`ifdef RTSNOC_RX_FIFO_FILTER_EN
    logic [2:0]            dst_local;
    logic [SOC_SIZE_Y-1:0] dst_y;
    logic [SOC_SIZE_X-1:0] dst_x;
    logic                  addr_match;
    logic                  drop;
    logic [7:0]            drop_cnt_q;

    assign dst_local  = rtr_dout_i[NOC_DATA_WIDTH +: 3];
    assign dst_y      = rtr_dout_i[NOC_DATA_WIDTH + 3 +: SOC_SIZE_Y];
    assign dst_x      = rtr_dout_i[NOC_DATA_WIDTH + 3 + SOC_SIZE_Y +: SOC_SIZE_X];
    assign addr_match = (dst_local == 3'(NOC_LOCAL_ADR)) &&
                        (dst_y == SOC_SIZE_Y'(NOC_Y)) &&
                        (dst_x == SOC_SIZE_X'(NOC_X));
    assign wr_en      = rtr_rd_q && addr_match;
    assign drop       = rtr_rd_q && !addr_match;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drop_cnt_q <= 8'd0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    assign wr_en      = rtr_rd_q;
    assign drop_cnt_o = 8'd0;
`endif

    // Only the rising edge of the slave's level-type read request pops.
    assign do_pop = noc_rd_i && !noc_rd_q && !empty;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            noc_rd_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            noc_rd_q <= noc_rd_i;
            if (wr_en) wr_ptr_q <= wr_ptr_q + (DEPTH_LOG2 + 1)'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + (DEPTH_LOG2 + 1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= rtr_dout_i;
    end

    assign noc_dout_o   = empty ? '0 : mem[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign noc_nd_o     = !empty;
    assign fifo_level_o = level;

endmodule

// File: tb/tb_rtsnoc_rx_fifo.sv
// Self-checking bench for rtsnoc_rx_fifo: queue-based router and FIFO reference model.
module tb_rtsnoc_rx_fifo;

    localparam int unsigned BUS = 26;

`ifdef RTSNOC_RX_FIFO_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n_i;
    logic [BUS-1:0] rtr_dout_i;
    logic           rtr_nd_i;
    logic           rtr_rd_o;
    logic [BUS-1:0] noc_dout_o;
    logic           noc_nd_o;
    logic           noc_rd_i;
    logic [3:0]     fifo_level_o;
    logic [7:0]     drop_cnt_o;

    rtsnoc_rx_fifo #(
        .SOC_SIZE_X     (1),
        .SOC_SIZE_Y     (1),
        .NOC_DATA_WIDTH (16),
        .NOC_LOCAL_ADR  (2),
        .NOC_X          (1),
        .NOC_Y          (0),
        .DEPTH_LOG2     (3)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n_i),
        .rtr_dout_i   (rtr_dout_i),
        .rtr_nd_i     (rtr_nd_i),
        .rtr_rd_o     (rtr_rd_o),
        .noc_dout_o   (noc_dout_o),
        .noc_nd_o     (noc_nd_o),
        .noc_rd_i     (noc_rd_i),
        .fifo_level_o (fifo_level_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    always #5 clk = ~clk;

    int unsigned    vectors = 0;
    int unsigned    miscompares = 0;
    logic [BUS-1:0] rq[$];     // flits the router still offers
    logic [BUS-1:0] exp_q[$];  // expected FIFO contents, head first
    int unsigned    drop_exp = 0;
    int unsigned    rd_pulses = 0;
    logic           prev_rd = 1'b0;
    logic           rd_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [BUS-1:0] mk(input logic [15:0] d, input logic xd, input logic yd,
                                          input logic [2:0] ld);
        logic       xo, yo;
        logic [2:0] lo;
        xo = 1'($urandom);
        yo = 1'($urandom);
        lo = 3'($urandom);
        return {xo, yo, lo, xd, yd, ld, d};
    endfunction

    function automatic logic [BUS-1:0] good(input logic [15:0] d);
        return mk(d, 1'b1, 1'b0, 3'd2);
    endfunction

    function automatic bit addr_ok(input logic [BUS-1:0] f);
        logic [BUS-1:0] t;
        t = f;
        return (t[20] == 1'b1) && (t[19] == 1'b0) && (t[18:16] == 3'd2);
    endfunction

    task automatic bus_update();
        if (!rtr_rd_o) begin
            rtr_nd_i   = (rq.size() != 0);
            rtr_dout_i = (rq.size() != 0) ? rq[0] : '0;
        end
    endtask

    task automatic check_outputs();
        int unsigned n;
        n = exp_q.size();
        chk("level", 32'(fifo_level_o), n);
        chk("nd", 32'(noc_nd_o), 32'(n != 0));
        chk("dout", 32'(noc_dout_o), (n != 0) ? 32'(exp_q[0]) : 32'd0);
        chk("drop", 32'(drop_cnt_o), drop_exp);
    endtask

    // Advance one clock: apply the model's view of the coming edge, then sample at the negedge.
    task automatic step();
        logic [BUS-1:0] f;
        if (rst_n_i) begin
            if (noc_rd_i && !prev_rd && exp_q.size() != 0) void'(exp_q.pop_front());
            if (rtr_rd_o) begin
                rd_pulses++;
                chk("rd_with_flit", 32'(rq.size() != 0), 32'd1);
                if (rq.size() != 0) begin
                    f = rq.pop_front();
                    if (!FILTER || addr_ok(f)) exp_q.push_back(f);
                    else if (drop_exp != 255) drop_exp++;
                end
            end
            prev_rd = noc_rd_i;
        end else begin
            prev_rd = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("rd_gap", 32'(rd_seen && rtr_rd_o), 32'd0);
        rd_seen = rtr_rd_o;
        bus_update();
        check_outputs();
    endtask

    task automatic pop_once();
        noc_rd_i = 1'b1;
        step();
        noc_rd_i = 1'b0;
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (exp_q.size() != 0 || rq.size() != 0 || rtr_rd_o); i++)
            pop_once();
        chk("drained", 32'(fifo_level_o), 32'd0);
    endtask

    task automatic do_reset();
        rst_n_i  = 1'b0;
        noc_rd_i = 1'b0;
        rq.delete();
        exp_q.delete();
        drop_exp = 0;
        prev_rd  = 1'b0;
        rd_seen  = 1'b0;
        #1;
        chk("rst_rd", 32'(rtr_rd_o), 32'd0);
        chk("rst_nd", 32'(noc_nd_o), 32'd0);
        chk("rst_dout", 32'(noc_dout_o), 32'd0);
        chk("rst_level", 32'(fifo_level_o), 32'd0);
        chk("rst_drop", 32'(drop_cnt_o), 32'd0);
        bus_update();
        step();
        step();
        rst_n_i = 1'b1;
    endtask

    initial begin
        int unsigned    base;
        logic [BUS-1:0] saved[3];

        rst_n_i    = 1'b0;
        rtr_nd_i   = 1'b0;
        rtr_dout_i = '0;
        noc_rd_i   = 1'b0;
        @(negedge clk);
        do_reset();
        step();

        // Single flit latency
        base = rd_pulses;
        rq.push_back(good(16'h1234));
        bus_update();
        step();
        chk("single_early_nd", 32'(noc_nd_o), 32'd0);
        step();
        chk("single_nd", 32'(noc_nd_o), 32'd1);
        chk("single_data", 32'(noc_dout_o[15:0]), 32'h1234);
        chk("single_level", 32'(fifo_level_o), 32'd1);
        repeat (6) step();
        chk("single_pulses", rd_pulses - base, 32'd1);
        drain();

        // Fill to full with back-pressure, then one pop releases one more fetch
        base = rd_pulses;
        for (int i = 0; i < 10; i++) rq.push_back(good(16'($urandom)));
        bus_update();
        repeat (40) step();
        chk("fill_pulses", rd_pulses - base, 32'd8);
        chk("fill_level", 32'(fifo_level_o), 32'd8);
        pop_once();
        repeat (3) step();
        chk("refill_pulses", rd_pulses - base, 32'd9);
        drain();

        // Held read pops exactly one flit
        for (int i = 0; i < 3; i++) begin
            saved[i] = good(16'($urandom));
            rq.push_back(saved[i]);
        end
        bus_update();
        repeat (15) step();
        chk("held_pre_level", 32'(fifo_level_o), 32'd3);
        noc_rd_i = 1'b1;
        repeat (5) step();
        noc_rd_i = 1'b0;
        step();
        chk("held_level", 32'(fifo_level_o), 32'd2);
        chk("held_head", 32'(noc_dout_o), 32'(saved[1]));
        drain();

        // Pop on empty FIFO is ignored
        pop_once();
        chk("empty_level", 32'(fifo_level_o), 32'd0);
        chk("empty_dout", 32'(noc_dout_o), 32'd0);
        rq.push_back(good(16'hBEEF));
        bus_update();
        repeat (4) step();
        chk("empty_after_data", 32'(noc_dout_o[15:0]), 32'hBEEF);
        drain();

        // Simultaneous write and pop at level 4
        for (int i = 0; i < 4; i++) rq.push_back(good(16'($urandom)));
        bus_update();
        repeat (20) step();
        chk("sim_pre_level", 32'(fifo_level_o), 32'd4);
        rq.push_back(good(16'($urandom)));
        bus_update();
        for (int i = 0; i < 10 && !rtr_rd_o; i++) step();
        chk("sim_wait", 32'(rtr_rd_o), 32'd1);
        noc_rd_i = 1'b1;
        step();
        chk("sim_level", 32'(fifo_level_o), 32'd4);
        noc_rd_i = 1'b0;
        step();
        drain();

        // Random traffic through pointer wrap
        base = rd_pulses;
        for (int i = 0; i < 20; i++) rq.push_back(good(16'($urandom)));
        bus_update();
        for (int i = 0; i < 400; i++) begin
            noc_rd_i = 1'($urandom_range(0, 1));
            step();
        end
        noc_rd_i = 1'b0;
        step();
        drain();
        chk("wrap_pulses", rd_pulses - base, 32'd20);

        // Destination filter
        base = rd_pulses;
        rq.push_back(mk(16'h0F0F, 1'b0, 1'b0, 3'd2));
        bus_update();
        repeat (6) step();
        chk("filter_pulses", rd_pulses - base, 32'd1);
`ifdef RTSNOC_RX_FIFO_FILTER_EN
        chk("filter_drop", 32'(drop_cnt_o), 32'd1);
        chk("filter_level0", 32'(fifo_level_o), 32'd0);
        rq.push_back(good(16'h5A5A));
        bus_update();
        repeat (6) step();
        chk("filter_level1", 32'(fifo_level_o), 32'd1);
        chk("filter_data", 32'(noc_dout_o[15:0]), 32'h5A5A);
`else
        chk("nofilter_drop", 32'(drop_cnt_o), 32'd0);
        chk("nofilter_level", 32'(fifo_level_o), 32'd1);
`endif
        drain();

        // Asynchronous reset during POP drops the in-flight flit
        rq.push_back(good(16'h7777));
        bus_update();
        for (int i = 0; i < 10 && !rtr_rd_o; i++) step();
        chk("rst_wait", 32'(rtr_rd_o), 32'd1);
        do_reset();
        repeat (6) step();
        chk("rst_lost_level", 32'(fifo_level_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
